// File: rtl/nios_handshake_mem_stream_reader_pkg.sv
// Shared types and widths for the on-chip RAM stream reader.
package nios_handshake_pkg;

   localparam int unsigned MEM_ADDR_W = 10;
   localparam int unsigned MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/nios_handshake_mem_stream_reader_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide at full or empty.
module nios_handshake_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_c;
   logic             do_pop_c;

   assign empty     = (count_q == '0);
   assign do_pop_c  = pop & ~empty;
   assign do_push_c = push & ((count_q != CNT_W'(DEPTH)) | do_pop_c);
   assign rdata     = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Next pointer/count/storage; flush discards everything including a same-cycle push.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
      end
   end

   // Storage and pointer registers; storage is cleared so the head word reads 0 out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/nios_handshake_mem_stream_reader.sv
// Credit-limited Avalon-MM read master draining a block of RAM words into a valid/ready stream.
module nios_handshake_mem_stream_reader
   import nios_handshake_pkg::*;
#(
   parameter int unsigned DATA_W     = MEM_DATA_W,
   parameter int unsigned ADDR_W     = MEM_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);
   localparam int unsigned LEN_W  = ADDR_W + 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CNT1_W = CNT_W + 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic                cs_q, cs_d;
   logic                inflight_q, inflight_d;
   logic                infl_last_q, infl_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_empty;
   logic [DATA_W:0]     fifo_rdata;
   logic                pop_c;
   logic                last_pop_c;
   logic [CNT1_W-1:0]   count_next_c;

   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;
   assign mem_address    = addr_q;
   assign mem_chipselect = cs_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign out_valid      = ~fifo_empty;
   assign out_data       = fifo_rdata[DATA_W-1:0];
   assign out_last       = fifo_rdata[DATA_W];
   assign pop_c          = out_valid & out_ready;
   assign last_pop_c     = pop_c & out_last;

   // Output buffer; the last flag rides alongside each data word.
   nios_handshake_sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (abort),
      .push    (inflight_q),
      .wdata   ({infl_last_q, mem_readdata}),
      .pop     (pop_c),
      .rdata   (fifo_rdata),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over everything, including start.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (cs_q && (rem_q == LEN_W'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Counters, credit check and registered outputs for the coming cycle.
   always_comb begin
      addr_d       = addr_q;
      rem_d        = rem_q;
      cs_d         = 1'b0;
      inflight_d   = 1'b0;
      infl_last_d  = 1'b0;
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      count_next_c = CNT1_W'(fifo_count) + CNT1_W'(inflight_q) - CNT1_W'(pop_c);
      if (!abort) begin
         inflight_d  = cs_q;
         infl_last_d = cs_q && (rem_q == LEN_W'(1));
         if ((state_q == ST_IDLE) && start) begin
            addr_d = base_addr;
            rem_d  = length;
         end else if (cs_q) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
         end
         // Next-cycle occupancy plus the read landing next cycle must leave room for one more.
         cs_d = (state_d == ST_RUN) && (rem_d != '0) &&
                ((count_next_c + CNT1_W'(cs_q)) < CNT1_W'(FIFO_DEPTH));
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q      <= '0;
         rem_q       <= '0;
         cs_q        <= 1'b0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         cs_q        <= cs_d;
         inflight_q  <= inflight_d;
         infl_last_q <= infl_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_nios_handshake_mem_stream_reader.sv
// Bench for the RAM stream reader: RAM model, stream monitor and per-scenario checks.
module tb_nios_handshake_mem_stream_reader;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned RAM_WORDS = 1024;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   length = '0;
   logic              busy, done, mem_chipselect, mem_write, mem_clken, out_valid, out_last;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic [DATA_W-1:0] mem_readdata, out_data;

   logic [DATA_W-1:0] ram [RAM_WORDS];
   logic [DATA_W-1:0] rd_q = '0;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] addr_log [$];
   int                cs_cyc [$];
   logic [DATA_W-1:0] data_log [$];
   bit                last_log [$];
   int                hs_cyc [$];
   int                done_cnt = 0;
   int                done_cyc = -1;
   int                busy_cnt = 0;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_last = 1'b0;

   nios_handshake_mem_stream_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .base_addr      (base_addr),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM: registered address, q valid the cycle after chipselect.
   always @(posedge clk) if (mem_chipselect) rd_q <= ram[mem_address];
   assign mem_readdata = rd_q;

   // Monitor at the falling edge: log reads, handshakes, done/busy; check stall hold.
   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_chipselect) begin addr_log.push_back(mem_address); cs_cyc.push_back(cyc); end
         if (out_valid && out_ready) begin
            data_log.push_back(out_data); last_log.push_back(out_last); hs_cyc.push_back(cyc);
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy) busy_cnt++;
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
               $display("FAIL stall_hold cyc %0d: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                        cyc, out_valid, out_data, out_last, prev_data, prev_last);
            else n_pass++;
         end
         prev_stall = out_valid && !out_ready && !abort;
         prev_data  = out_data;
         prev_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      addr_log.delete(); cs_cyc.delete(); data_log.delete(); last_log.delete(); hs_cyc.delete();
      done_cnt = 0; done_cyc = -1; busy_cnt = 0;
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, output int sc);
      step();
      start = 1'b1; base_addr = b; length = l; sc = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rand_ready, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) begin ok = 1'b1; break; end
         step();
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
      if (done_cnt > 0) ok = 1'b1;
   endtask

   // Reference: word i of a transfer reads address (b+i) mod 1024; only word len-1 carries last.
   function automatic int addr_bad(input int b, input int l);
      for (int i = 0; i < l; i++) begin
         if (i >= addr_log.size()) return i;
         if (addr_log[i] !== ADDR_W'((b + i) % RAM_WORDS)) return i;
      end
      if (addr_log.size() != l) return l;
      return -1;
   endfunction

   function automatic int data_bad(input int b, input int l);
      for (int i = 0; i < l; i++) begin
         if (i >= data_log.size()) return i;
         if (data_log[i] !== ram[(b + i) % RAM_WORDS]) return i;
         if (last_log[i] != (i == l - 1)) return i;
      end
      if (data_log.size() != l) return l;
      return -1;
   endfunction

   task automatic test_reset();
      #2;
      n_checks++;
      if ({busy, done, mem_chipselect, out_valid, out_last} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {busy, done, mem_chipselect, out_valid, out_last});
      else n_pass++;
      n_checks++;
      if (mem_address !== '0 || out_data !== '0)
         $display("FAIL reset_addr_data: got addr=%h data=%h want 0/0", mem_address, out_data);
      else n_pass++;
      n_checks++;
      if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1)
         $display("FAIL mem_constants: got wr=%b be=%h clken=%b want 0/F/1", mem_write, mem_byteenable, mem_clken);
      else n_pass++;
      step(); step();
      reset_n = 1'b1;
      step();
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL idle_after_reset: got busy=%b valid=%b want 0/0", busy, out_valid);
      else n_pass++;
   endtask

   task automatic test_transfer(input string name, input logic [ADDR_W-1:0] b, input int l);
      int sc; bit ok; int e;
      clear_logs(); out_ready = 1'b1;
      pulse_start(b, ADDR_W'(0) + (ADDR_W+1)'(l), sc);
      run_until_done(100, 1'b0, ok);
      step(); step();
      n_checks++;
      if (!ok) $display("FAIL %s_timeout: got done_cnt=%0d want 1", name, done_cnt); else n_pass++;
      e = addr_bad(int'(b), l);
      n_checks++;
      if (e >= 0) $display("FAIL %s_addr: first bad index %0d, got %0d reads want %0d", name, e, addr_log.size(), l);
      else n_pass++;
      e = data_bad(int'(b), l);
      n_checks++;
      if (e >= 0) $display("FAIL %s_data: first bad index %0d, got %0d words want %0d", name, e, data_log.size(), l);
      else n_pass++;
      n_checks++;
      if (cs_cyc.size() == 0 || cs_cyc[0] != sc + 1)
         $display("FAIL %s_first_cs: got cyc %0d want %0d", name, (cs_cyc.size() > 0) ? cs_cyc[0] : -1, sc + 1);
      else n_pass++;
      n_checks++;
      if (hs_cyc.size() != l || done_cnt != 1 || done_cyc != hs_cyc[l-1] + 1)
         $display("FAIL %s_done_timing: got done_cnt=%0d cyc %0d want 1 pulse one cycle after last handshake",
                  name, done_cnt, done_cyc);
      else n_pass++;
      n_checks++;
      if (hs_cyc.size() != l || hs_cyc[l-1] - hs_cyc[0] != l - 1)
         $display("FAIL %s_zero_bubble: got span %0d want %0d", name,
                  (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : -1, l - 1);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL %s_idle: got busy=%b want 0", name, busy); else n_pass++;
   endtask

   task automatic test_zero_len();
      int sc;
      clear_logs(); out_ready = 1'b1;
      pulse_start(ADDR_W'($urandom_range(0, RAM_WORDS - 1)), '0, sc);
      repeat (4) step();
      n_checks++;
      if (addr_log.size() != 0) $display("FAIL zero_len_reads: got %0d want 0", addr_log.size()); else n_pass++;
      n_checks++;
      if (done_cnt != 1 || done_cyc != sc + 1)
         $display("FAIL zero_len_done: got cnt=%0d cyc=%0d want 1 at %0d", done_cnt, done_cyc, sc + 1);
      else n_pass++;
      n_checks++;
      if (busy_cnt != 1) $display("FAIL zero_len_busy: got %0d cycles want 1", busy_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      int sc; bit ok; int e;
      logic [ADDR_W-1:0] b;
      b = ADDR_W'($urandom_range(0, RAM_WORDS - 1));
      clear_logs(); out_ready = 1'b0;
      pulse_start(b, 11'd8, sc);
      repeat (20) step();
      n_checks++;
      if (addr_log.size() != 4) $display("FAIL stall_reads: got %0d want 4", addr_log.size()); else n_pass++;
      n_checks++;
      if (out_valid !== 1'b1 || data_log.size() != 0)
         $display("FAIL stall_valid: got valid=%b words=%0d want 1/0", out_valid, data_log.size());
      else n_pass++;
      out_ready = 1'b1;
      run_until_done(100, 1'b0, ok);
      n_checks++;
      if (!ok) $display("FAIL stall_timeout: got done_cnt=%0d want 1", done_cnt); else n_pass++;
      e = data_bad(int'(b), 8);
      n_checks++;
      if (e >= 0) $display("FAIL stall_data: first bad index %0d, got %0d words want 8", e, data_log.size());
      else n_pass++;
   endtask

   task automatic test_abort();
      int sc; bit ok; int e; bit seen;
      clear_logs(); out_ready = 1'b1;
      pulse_start(ADDR_W'($urandom_range(0, RAM_WORDS - 1)), 11'd10, sc);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (hs_cyc.size() >= 3) begin seen = 1'b1; break; end
         step();
      end
      n_checks++;
      if (!seen) $display("FAIL abort_setup: got %0d words want 3", hs_cyc.size()); else n_pass++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || mem_chipselect !== 1'b0)
         $display("FAIL abort_idle: got busy=%b valid=%b cs=%b want 0/0/0", busy, out_valid, mem_chipselect);
      else n_pass++;
      repeat (3) step();
      n_checks++;
      if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); else n_pass++;
      clear_logs();
      pulse_start(10'h100, 11'd2, sc);
      run_until_done(50, 1'b0, ok);
      step();
      e = data_bad(32'h100, 2);
      n_checks++;
      if (!ok || e >= 0) $display("FAIL abort_restart: ok=%b bad index %0d, got %0d words want 2", ok, e, data_log.size());
      else n_pass++;
   endtask

   task automatic test_reset_drain_full();
      int sc; bit ok; int e;
      logic [ADDR_W-1:0] b;
      clear_logs(); out_ready = 1'b1;
      pulse_start(ADDR_W'($urandom_range(0, RAM_WORDS - 1)), 11'd1024, sc);
      for (int i = 0; i < 6000; i++) begin
         if (addr_log.size() >= 1024) break;
         step();
         out_ready = ($urandom_range(0, 3) != 0);
      end
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || addr_log.size() != 1024)
         $display("FAIL drain_reached: got busy=%b done=%b reads=%0d want 1/0/1024", busy, done, addr_log.size());
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, mem_chipselect, out_valid, out_last} !== 5'b0 || out_data !== '0 || mem_address !== '0)
         $display("FAIL async_reset: got flags=%b data=%h addr=%h want 0", {busy, done, mem_chipselect, out_valid, out_last},
                  out_data, mem_address);
      else n_pass++;
      step(); step();
      reset_n = 1'b1;
      step();
      b = ADDR_W'($urandom_range(0, RAM_WORDS - 1));
      clear_logs();
      pulse_start(b, 11'd1024, sc);
      run_until_done(8000, 1'b1, ok);
      step();
      n_checks++;
      if (!ok || done_cnt != 1) $display("FAIL full_done: ok=%b got %0d pulses want 1", ok, done_cnt); else n_pass++;
      e = addr_bad(int'(b), 1024);
      n_checks++;
      if (e >= 0) $display("FAIL full_addr: first bad index %0d, got %0d reads want 1024", e, addr_log.size());
      else n_pass++;
      e = data_bad(int'(b), 1024);
      n_checks++;
      if (e >= 0) $display("FAIL full_data: first bad index %0d, got %0d words want 1024", e, data_log.size());
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < int'(RAM_WORDS); i++) ram[i] = $urandom;
      test_reset();
      test_transfer("basic", 10'h010, 4);
      test_transfer("wrap", 10'h3FE, 4);
      test_zero_len();
      test_backpressure();
      test_abort();
      test_reset_drain_full();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
